// File: rtl/parallel_mul_param.sv
// Unsigned WIDTH x WIDTH multiplier: LANES serial radix-2^DIGIT lanes over slices of In2, then a SUM pass.
// Define PMUL_ZERO_SKIP_EN to return 0 in one cycle when either accepted operand is zero.
module parallel_mul_param #(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned LANES = 4,
  parameter int unsigned DIGIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     In1,
  input  logic [WIDTH-1:0]     In2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Out,
  output logic                 busy
);

  localparam int unsigned SLICE = WIDTH / LANES;
  localparam int unsigned STEPS = SLICE / DIGIT;
  localparam int unsigned ACCW  = WIDTH + SLICE;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_SUM  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
`ifdef PMUL_ZERO_SKIP_EN
  localparam logic [2:0] S_ZERO = 3'd4;
`endif

  logic [2:0]              state;
  logic [WIDTH-1:0]        a;
  logic [SLICE-1:0]        bs   [LANES];
  logic [ACCW-1:0]         acc  [LANES];
  logic [WIDTH+DIGIT-1:0]  prod [LANES];
  logic [CW-1:0]           cnt;
  logic [LW-1:0]           lane;
  logic [PW-1:0]           total;
  logic [PW-1:0]           term;

  // Each lane's multiplier slice shifts left, so its next digit is always the top DIGIT bits.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign prod[k] = {{DIGIT{1'b0}}, a} * (WIDTH+DIGIT)'(bs[k][SLICE-1 -: DIGIT]);
  end

  assign term     = PW'(acc[lane]) << (32'(lane) * SLICE);
  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_MUL) || (state == S_SUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      a         <= '0;
      cnt       <= '0;
      lane      <= '0;
      total     <= '0;
      Out       <= '0;
      out_valid <= 1'b0;
      for (int unsigned k = 0; k < LANES; k++) begin
        bs[k]  <= '0;
        acc[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a     <= In1;
            cnt   <= '0;
            lane  <= '0;
            total <= '0;
            for (int unsigned k = 0; k < LANES; k++) begin
              bs[k]  <= In2[k*SLICE +: SLICE];
              acc[k] <= '0;
            end
`ifdef PMUL_ZERO_SKIP_EN
            if (In1 == '0 || In2 == '0) state <= S_ZERO;
            else                        state <= S_MUL;
`else
            state <= S_MUL;
`endif
          end
        end
        S_MUL: begin
          for (int unsigned k = 0; k < LANES; k++) begin
            acc[k] <= (acc[k] << DIGIT) + ACCW'(prod[k]);
            bs[k]  <= bs[k] << DIGIT;
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(STEPS - 1)) state <= S_SUM;
        end
        S_SUM: begin
          total <= total + term;
          lane  <= lane + 1'b1;
          if (lane == LW'(LANES - 1)) begin
            Out       <= total + term;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
`ifdef PMUL_ZERO_SKIP_EN
        S_ZERO: begin
          Out       <= '0;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_mul_param.sv
// Bench for parallel_mul_param: two 16-bit configurations plus the 1024-bit default, checked against plain multiplication.
module tb_parallel_mul_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic        iv [2];
  logic        ir [2];
  logic        ov [2];
  logic        ordy [2];
  logic        bz [2];
  logic [15:0] i1 [2];
  logic [15:0] i2 [2];
  logic [31:0] o  [2];

  logic          biv, bir, bov, bordy, bbz;
  logic [1023:0] b1, b2;
  logic [2047:0] bo;

  parallel_mul_param #(.WIDTH(16), .LANES(4), .DIGIT(1)) u_s0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .In1(i1[0]), .In2(i2[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .Out(o[0]), .busy(bz[0]));

  parallel_mul_param #(.WIDTH(16), .LANES(2), .DIGIT(2)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .In1(i1[1]), .In2(i2[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .Out(o[1]), .busy(bz[1]));

  parallel_mul_param #(.WIDTH(1024), .LANES(4), .DIGIT(1)) u_big (
    .clk(clk), .rst(rst), .in_valid(biv), .in_ready(bir), .In1(b1), .In2(b2),
    .out_valid(bov), .out_ready(bordy), .Out(bo), .busy(bbz));

  task automatic check(input string tag, input logic [2047:0] obs, input logic [2047:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs[511:0], exp[511:0]);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rand1k(output logic [1023:0] v);
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
  endtask

  // One job on a 16-bit instance; expected product is plain arithmetic on the operands.
  task automatic job16(input int s, input logic [15:0] x, input logic [15:0] y,
                       input int hold, input int exp_lat, input logic exp_busy);
    logic [31:0] e;
    int lat;
    e = 32'(x) * 32'(y);
    check($sformatf("s%0d_in_ready_idle", s), ir[s], 1);
    i1[s] = x;
    i2[s] = y;
    iv[s] = 1'b1;
    step;
    iv[s] = 1'b0;
    i1[s] = 16'($urandom);
    i2[s] = 16'($urandom);
    check($sformatf("s%0d_busy", s), bz[s], exp_busy);
    check($sformatf("s%0d_in_ready_low", s), ir[s], 0);
    lat = 0;
    while (!ov[s] && lat < 100) begin
      step;
      lat++;
    end
    check($sformatf("s%0d_latency", s), lat, exp_lat);
    check($sformatf("s%0d_product", s), o[s], e);
    for (int h = 0; h < hold; h++) begin
      step;
      check($sformatf("s%0d_hold_out", s), o[s], e);
      check($sformatf("s%0d_hold_valid", s), ov[s], 1);
      check($sformatf("s%0d_hold_in_ready", s), ir[s], 0);
    end
    ordy[s] = 1'b1;
    step;
    ordy[s] = 1'b0;
    check($sformatf("s%0d_valid_cleared", s), ov[s], 0);
    check($sformatf("s%0d_in_ready_back", s), ir[s], 1);
    check($sformatf("s%0d_out_retained", s), o[s], e);
  endtask

  logic [2047:0] qexp [$];
  int            qacc [$];
  int            cyc, accepted, done, prev;
  logic          acc_now;

  initial begin
    for (int s = 0; s < 2; s++) begin
      iv[s] = 1'b0; ordy[s] = 1'b0; i1[s] = '0; i2[s] = '0;
    end
    biv = 1'b0; bordy = 1'b0; b1 = '0; b2 = '0;
    rst = 1'b1;
    repeat (3) step;
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      check($sformatf("s%0d_rst_out_valid", s), ov[s], 0);
      check($sformatf("s%0d_rst_in_ready", s), ir[s], 1);
      check($sformatf("s%0d_rst_busy", s), bz[s], 0);
      check($sformatf("s%0d_rst_out", s), o[s], 0);
    end
    check("big_rst_out_valid", bov, 0);
    check("big_rst_in_ready", bir, 1);
    check("big_rst_out", bo, 0);

    job16(0, 16'hFFFF, 16'hFFFF, 5, 8, 1'b1);
    job16(0, 16'h1234, 16'h00FF, 0, 8, 1'b1);
    job16(1, 16'h8000, 16'h8000, 0, 6, 1'b1);
    job16(1, 16'hFFFF, 16'hFFFF, 2, 6, 1'b1);
    for (int r = 0; r < 4; r++) begin
      job16(0, 16'($urandom), 16'($urandom), 0, 8, 1'b1);
      job16(1, 16'($urandom), 16'($urandom), 0, 6, 1'b1);
    end

    // Abort mid-MUL: no output may appear, then a fresh job must complete normally.
    i1[0] = 16'hBEEF; i2[0] = 16'hCAFE; iv[0] = 1'b1;
    step;
    iv[0] = 1'b0;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("abort_in_ready", ir[0], 1);
    check("abort_busy", bz[0], 0);
    check("abort_out_valid", ov[0], 0);
    repeat (10) step;
    check("abort_no_stale_valid", ov[0], 0);
    job16(0, 16'd3, 16'd5, 0, 8, 1'b1);

`ifdef PMUL_ZERO_SKIP_EN
    job16(0, 16'hABCD, 16'h0000, 0, 1, 1'b0);
    job16(0, 16'h0000, 16'h1234, 0, 1, 1'b0);
`else
    job16(0, 16'hABCD, 16'h0000, 0, 8, 1'b1);
    job16(0, 16'h0000, 16'h1234, 0, 8, 1'b1);
`endif

    // Default configuration: 10 back-to-back jobs, in_valid held and out_ready always high.
    b1 = '1;
    b2 = '1;
    biv = 1'b1;
    bordy = 1'b1;
    cyc = 0; accepted = 0; done = 0; prev = -1;
    while (done < 10 && cyc < 5000) begin
      if (bir && bov) check("big_ready_valid_overlap", 1, 0);
      if (bov) begin
        if (qexp.size() == 0) begin
          check("big_spurious_out_valid", 1, 0);
        end else begin
          check("big_product", bo, qexp.pop_front());
          check("big_latency", cyc - qacc.pop_front(), 260);
        end
        if (prev >= 0) check("big_period", cyc - prev, 262);
        prev = cyc;
        done++;
      end
      acc_now = biv && bir;
      if (acc_now) begin
        qexp.push_back(2048'(b1) * 2048'(b2));
        qacc.push_back(cyc + 1);
        accepted++;
      end
      step;
      cyc++;
      if (acc_now) begin
        if (accepted == 10) biv = 1'b0;
        else begin
          rand1k(b1);
          rand1k(b2);
        end
      end
    end
    check("big_jobs_done", done, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
